lr_shift_seq: RTL and testbench

- Parametrised, clocked successor to the 8-bit combinational left/right shifter.
- Registered WIDTH-bit universal shift register with these operations:
  - hold, parallel load
  - logical shift left/right with serial-in
  - rotate left/right
  - arithmetic shift right
  - sequenced multi-step shift of Amt positions, one position per clock, with Busy/Done handshake.
- Used as a datapath shifter and serialiser between register stages of the assignment designs.

---
 rtl/lr_shift_seq.sv | 117 +++++++++++
 tb/tb_lr_shift_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lr_shift_seq.sv
// lr_shift_seq: registered WIDTH-bit universal shift register with single-cycle
// ops (hold/load/shift/rotate/arith-right) and a sequenced multi-step shift of
// Amt positions, one position per clock, reported through Busy/Done.
// Ports: Clk, Rst_n (sync, active-low); Op/In/Si single-cycle controls;
// Start/Dir/Amt multi-step request; Out, So_L, So_R, Busy, Done, Zero status.
module lr_shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] In,
  input  logic             Si,
  input  logic             Start,
  input  logic             Dir,
  input  logic [AMT_W-1:0] Amt,
  output logic [WIDTH-1:0] Out,
  output logic             So_L,
  output logic             So_R,
  output logic             Busy,
  output logic             Done,
  output logic             Zero
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] ONE_AMT   = AMT_W'(1);

  state_t           state, state_nxt;
  logic [AMT_W-1:0] count, count_nxt;
  logic             dir, dir_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic             done, done_nxt;

  logic [AMT_W-1:0] amt_sat;
  logic [WIDTH-1:0] shl_si;
  logic [WIDTH-1:0] shr_si;

  // Shifting more than WIDTH places cannot change the result further, so the
  // count saturates: the register ends up entirely Si-filled.
  assign amt_sat = (Amt > WIDTH_AMT) ? WIDTH_AMT : Amt;

  assign shl_si = {data[WIDTH-2:0], Si};
  assign shr_si = {Si, data[WIDTH-1:1]};

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      count <= '0;
      dir   <= 1'b0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      dir   <= dir_nxt;
      data  <= data_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    dir_nxt   = dir;
    data_nxt  = data;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Start takes priority; Op is ignored on a Start edge.
        if (Start) begin
          dir_nxt   = Dir;
          count_nxt = amt_sat;
          if (amt_sat != '0) begin
            state_nxt = SHIFT;
          end else begin
            // Zero-length request completes immediately with no shifting.
            done_nxt = 1'b1;
          end
        end else begin
          case (Op)
            3'b001:  data_nxt = In;
            3'b010:  data_nxt = shl_si;
            3'b011:  data_nxt = shr_si;
            3'b100:  data_nxt = {data[WIDTH-2:0], data[WIDTH-1]};
            3'b101:  data_nxt = {data[0], data[WIDTH-1:1]};
            3'b110:  data_nxt = {data[WIDTH-1], data[WIDTH-1:1]};
            default: data_nxt = data;
          endcase
        end
      end
      SHIFT: begin
        // All request inputs are ignored here; only Si is consumed.
        data_nxt  = dir ? shr_si : shl_si;
        count_nxt = count - ONE_AMT;
        if (count == ONE_AMT) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Out  = data;
  assign So_L = data[WIDTH-1];
  assign So_R = data[0];
  assign Busy = (state == SHIFT);
  assign Done = done;
  assign Zero = (data == '0);

endmodule

// File: tb/tb_lr_shift_seq.sv
module tb_lr_shift_seq;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [2:0]   Op;
  logic [W-1:0] In;
  logic         Si;
  logic         Start;
  logic         Dir;
  logic [3:0]   Amt;
  logic [W-1:0] Out;
  logic         So_L, So_R, Busy, Done, Zero;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model state: value as an integer, remaining shifts, direction.
  int m_out  = 0;
  int m_rem  = 0;
  int m_dir  = 0;
  int m_done = 0;

  lr_shift_seq #(.WIDTH(W), .AMT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Op(Op), .In(In), .Si(Si), .Start(Start),
    .Dir(Dir), .Amt(Amt), .Out(Out), .So_L(So_L), .So_R(So_R),
    .Busy(Busy), .Done(Done), .Zero(Zero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic model of one clock edge, using the inputs present at the edge.
  task automatic model_update();
    int si;
    int n;
    si = int'(Si);
    if (!Rst_n) begin
      m_out = 0; m_rem = 0; m_dir = 0; m_done = 0;
    end else if (m_rem > 0) begin
      if (m_dir == 0) m_out = (m_out * 2 + si) % 256;
      else            m_out = m_out / 2 + si * 128;
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0) ? 1 : 0;
    end else begin
      m_done = 0;
      if (Start) begin
        n = (int'(Amt) > W) ? W : int'(Amt);
        if (n == 0) m_done = 1;
        else begin
          m_rem = n;
          m_dir = int'(Dir);
        end
      end else begin
        case (Op)
          3'd1: m_out = int'(In);
          3'd2: m_out = (m_out * 2 + si) % 256;
          3'd3: m_out = m_out / 2 + si * 128;
          3'd4: m_out = (m_out * 2) % 256 + m_out / 128;
          3'd5: m_out = m_out / 2 + (m_out % 2) * 128;
          3'd6: m_out = m_out / 2 + (m_out / 128) * 128;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_out",  int'(Out),  m_out);
      chk("model_sol",  int'(So_L), m_out / 128);
      chk("model_sor",  int'(So_R), m_out % 2);
      chk("model_zero", int'(Zero), (m_out == 0) ? 1 : 0);
      chk("model_busy", int'(Busy), (m_rem > 0) ? 1 : 0);
      chk("model_done", int'(Done), m_done);
    end
  end

  task automatic load(input logic [W-1:0] v);
    Op = 3'b001; In = v; Start = 1'b0;
    step();
    Op = 3'b000;
  endtask

  task automatic single_op(input logic [2:0] op, input logic si);
    Op = op; Si = si; Start = 1'b0;
    step();
    Op = 3'b000;
  endtask

  // Issues a multi-step request, then observes a bounded window of cycles.
  task automatic run_seq(input logic d, input logic [3:0] a, input logic si,
                         output int busy_cnt, output int done_cnt,
                         output int first_done, output logic [W-1:0] out_at_done);
    busy_cnt = 0; done_cnt = 0; first_done = -1; out_at_done = 'x;
    Start = 1'b1; Dir = d; Amt = a; Si = si; Op = 3'b000;
    step();
    Start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        out_at_done = Out;
        if (first_done < 0) first_done = k;
      end
      step();
    end
  endtask

  initial begin
    int bc, dc, fd;
    logic [W-1:0] od;

    Rst_n = 1'b0; Op = 3'b000; In = '0; Si = 1'b0; Start = 1'b0; Dir = 1'b0; Amt = '0;
    step(); step();
    Rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset state, applied over a loaded value.
    load(8'hA5);
    chk("loaded_a5", int'(Out), 8'hA5);
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    chk("rst_out",  int'(Out),  0);
    chk("rst_zero", int'(Zero), 1);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);

    // Single-cycle operations.
    load(8'b1001_0110); single_op(3'b010, 1'b1); chk("op_shl",  int'(Out), 8'b0010_1101);
    load(8'b1001_0110); single_op(3'b011, 1'b0); chk("op_shr",  int'(Out), 8'b0100_1011);
    load(8'b1001_0110); single_op(3'b100, 1'b0); chk("op_rol",  int'(Out), 8'b0010_1101);
    load(8'b1001_0110); single_op(3'b101, 1'b1); chk("op_ror",  int'(Out), 8'b0100_1011);
    load(8'b1000_0000); single_op(3'b110, 1'b0); chk("op_asr",  int'(Out), 8'b1100_0000);
    load(8'h3C);        single_op(3'b111, 1'b1); chk("op_rsvd", int'(Out), 8'h3C);

    // Multi-step left by 3: Busy spans edges E0..E3, i.e. 3 sampled cycles.
    load(8'hF0);
    run_seq(1'b0, 4'd3, 1'b0, bc, dc, fd, od);
    chk("ms_left_busy_cycles", bc, 3);
    chk("ms_left_done_count",  dc, 1);
    chk("ms_left_out_at_done", int'(od), 8'h80);
    chk("ms_left_done_at",     fd, 3);

    // Amt=0 completes immediately.
    load(8'h5A);
    run_seq(1'b0, 4'd0, 1'b1, bc, dc, fd, od);
    chk("amt0_busy_cycles", bc, 0);
    chk("amt0_done_at",     fd, 0);
    chk("amt0_done_count",  dc, 1);
    chk("amt0_out",         int'(Out), 8'h5A);

    // Saturation: Amt=15 right with Si=1 acts as 8 shifts.
    load(8'h00);
    run_seq(1'b1, 4'd15, 1'b1, bc, dc, fd, od);
    chk("sat_busy_cycles", bc, 8);
    chk("sat_out",         int'(od), 8'hFF);
    chk("sat_done_count",  dc, 1);

    // Interference while Busy: load and Start must both be ignored.
    load(8'h3C);
    Start = 1'b1; Dir = 1'b1; Amt = 4'd2; Si = 1'b0; Op = 3'b000;
    step();
    Op = 3'b001; In = 8'h55; Start = 1'b1; Amt = 4'd7; Dir = 1'b0;
    step();
    step();
    Op = 3'b000; Start = 1'b0;
    chk("intf_done", int'(Done), 1);
    chk("intf_out",  int'(Out),  8'h0F);
    step();
    chk("intf_busy_after", int'(Busy), 0);
    chk("intf_out_after",  int'(Out),  8'h0F);

    // Reset on the second shift edge aborts the sequence with no Done.
    load(8'hFF);
    Start = 1'b1; Dir = 1'b0; Amt = 4'd5; Si = 1'b0;
    step();
    Start = 1'b0;
    step();
    chk("midrst_first_shift", int'(Out), 8'hFE);
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    chk("midrst_busy", int'(Busy), 0);
    chk("midrst_out",  int'(Out),  0);
    step();
    chk("midrst_no_done", int'(Done), 0);

    // Start beats Op on the same edge.
    load(8'h81);
    Start = 1'b1; Op = 3'b001; In = 8'h55; Dir = 1'b0; Amt = 4'd1; Si = 1'b0;
    step();
    Start = 1'b0; Op = 3'b000;
    chk("prio_busy", int'(Busy), 1);
    chk("prio_out0", int'(Out),  8'h81);
    step();
    chk("prio_done", int'(Done), 1);
    chk("prio_out",  int'(Out),  8'h02);

    // Randomised traffic checked every cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      Rst_n = ($urandom_range(0, 79) != 0);
      Op    = 3'($urandom_range(0, 7));
      In    = 8'($urandom);
      Si    = 1'($urandom);
      Start = ($urandom_range(0, 5) == 0);
      Dir   = 1'($urandom);
      Amt   = 4'($urandom);
      step();
    end
    Rst_n = 1'b1; Start = 1'b0; Op = 3'b000;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
